// File: rtl/program_store_pkg.sv
// Shared definitions for the program store: instruction opcodes and FSM state type.
package program_store_pkg;

  localparam logic [3:0] OpLda  = 4'b0000;
  localparam logic [3:0] OpLdb  = 4'b0001;
  localparam logic [3:0] OpLdo  = 4'b0010;
  localparam logic [3:0] OpLdsa = 4'b0011;
  localparam logic [3:0] OpLdsb = 4'b0100;
  localparam logic [3:0] OpLsh  = 4'b0101;
  localparam logic [3:0] OpRsh  = 4'b0110;
  localparam logic [3:0] OpClr  = 4'b0111;
  localparam logic [3:0] OpSnza = 4'b1000;
  localparam logic [3:0] OpSnzs = 4'b1001;
  localparam logic [3:0] OpAdd  = 4'b1010;
  localparam logic [3:0] OpSub  = 4'b1011;
  localparam logic [3:0] OpXor  = 4'b1110;

  typedef enum logic {StFill, StReady} state_e;

endpackage

// File: rtl/program_store_if.sv
// Fetch, load and clear signals of the program store.
//   master: requester side (drives fetch/load/clear requests)
//   slave : store side (returns fetched word, load handshake, busy)
interface program_store_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  fetchEnIn;
  logic [ADDR_WIDTH-1:0] addressIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValidOut;
  logic                  loadValidIn;
  logic [ADDR_WIDTH-1:0] loadAddrIn;
  logic [DATA_WIDTH-1:0] loadDataIn;
  logic                  loadReadyOut;
  logic                  loadErrOut;
  logic                  clearReqIn;
  logic                  busyOut;

  modport master (
    output fetchEnIn, addressIn, loadValidIn, loadAddrIn, loadDataIn, clearReqIn,
    input  dataOut, dataValidOut, loadReadyOut, loadErrOut, busyOut
  );

  modport slave (
    input  fetchEnIn, addressIn, loadValidIn, loadAddrIn, loadDataIn, clearReqIn,
    output dataOut, dataValidOut, loadReadyOut, loadErrOut, busyOut
  );
endinterface

// File: rtl/program_store_mem.sv
// Program word array: one synchronous write port, one synchronous read port.
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata updates only when re is set, holds otherwise
// Reads return the word stored before a same-edge write. The array has no reset.
module program_store_mem #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/program_store.sv
// Program store: instruction memory filled with NOP_WORD after reset or on a clear
// request, loaded word by word, and fetched with one cycle of latency.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : fetch / load / clear interface (slave side)
module program_store
  import program_store_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(OpClr)
) (
  input logic            clk,
  input logic            rst_n,
  program_store_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthW  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  valid_q;
  logic                  mem_sel_q;  // dataOut comes from the array, else NOP_WORD
  logic                  err_q;

  logic                  ready, fill;
  logic                  fetch_fire, load_fire;
  logic                  fetch_in_range, load_in_range;
  logic                  mem_we, mem_re;
  logic [IdxW-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  assign ready          = (state_q == StReady);
  assign fill           = (state_q == StFill);
  assign fetch_fire     = bus.fetchEnIn & ready;
  assign load_fire      = bus.loadValidIn & ready;
  assign fetch_in_range = ({1'b0, bus.addressIn} < DepthW);
  assign load_in_range  = ({1'b0, bus.loadAddrIn} < DepthW);

  // Sweep owns the write port in FILL; loads can only fire in READY.
  assign mem_we    = fill | (load_fire & load_in_range);
  assign mem_waddr = fill ? cnt_q[IdxW-1:0] : bus.loadAddrIn[IdxW-1:0];
  assign mem_wdata = fill ? NOP_WORD : bus.loadDataIn;
  assign mem_re    = fetch_fire & fetch_in_range;

  program_store_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IdxW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (bus.addressIn[IdxW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFill: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
        if (bus.clearReqIn) begin
          state_d = StFill;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      mem_sel_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= fetch_fire;
      if (fetch_fire) mem_sel_q <= fetch_in_range;
      err_q   <= load_fire & ~load_in_range;
    end
  end

  assign bus.dataOut      = mem_sel_q ? mem_rdata : NOP_WORD;
  assign bus.dataValidOut = valid_q;
  assign bus.loadReadyOut = ready;
  assign bus.loadErrOut   = err_q;
  assign bus.busyOut      = fill;
endmodule

// File: tb/tb_program_store.sv
// Directed self-checking bench for program_store.
module tb_program_store;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  program_store_if #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) bus ();

  program_store dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [3:0] Nop = 4'b0111;

  logic [3:0] prog [8] = '{4'b0000, 4'b0001, 4'b1010, 4'b0010,
                           4'b1011, 4'b0010, 4'b1110, 4'b0010};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetchEnIn   = 1'b0;
    bus.addressIn   = '0;
    bus.loadValidIn = 1'b0;
    bus.loadAddrIn  = '0;
    bus.loadDataIn  = '0;
    bus.clearReqIn  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (bus.dataOut !== Nop) begin fails++;
      $display("FAIL reset_data: got %b expected %b", bus.dataOut, Nop); end
    checks++; if (bus.dataValidOut !== 1'b0) begin fails++;
      $display("FAIL reset_valid: got %b expected 0", bus.dataValidOut); end
    checks++; if (bus.busyOut !== 1'b1) begin fails++;
      $display("FAIL reset_busy: got %b expected 1", bus.busyOut); end
    checks++; if (bus.loadReadyOut !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %b expected 0", bus.loadReadyOut); end
    checks++; if (bus.loadErrOut !== 1'b0) begin fails++;
      $display("FAIL reset_err: got %b expected 0", bus.loadErrOut); end
    rst_n = 1'b1;
    n = 0;
    while (bus.busyOut === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n != 32) begin fails++;
      $display("FAIL reset_fill_len: got %0d cycles expected 32", n); end
  endtask

  task automatic test_fill_contents();
    for (int a = 0; a < 32; a++) begin
      bus.fetchEnIn = 1'b1;
      bus.addressIn = 8'(a);
      tick();
      checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== Nop) begin fails++;
        $display("FAIL fill_fetch[%0d]: got v=%b d=%b expected v=1 d=%b",
                 a, bus.dataValidOut, bus.dataOut, Nop); end
    end
    idle();
    tick();
    checks++; if (bus.dataValidOut !== 1'b0 || bus.dataOut !== Nop) begin fails++;
      $display("FAIL idle_hold: got v=%b d=%b expected v=0 d=%b",
               bus.dataValidOut, bus.dataOut, Nop); end
  endtask

  task automatic test_load();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.loadReadyOut !== 1'b1) begin fails++;
        $display("FAIL load_ready[%0d]: got %b expected 1", i, bus.loadReadyOut); end
      bus.loadValidIn = 1'b1;
      bus.loadAddrIn  = 8'(i);
      bus.loadDataIn  = prog[i];
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.fetchEnIn = 1'b1;
      bus.addressIn = 8'(i);
      tick();
      checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== prog[i]) begin fails++;
        $display("FAIL load_fetch[%0d]: got v=%b d=%b expected v=1 d=%b",
                 i, bus.dataValidOut, bus.dataOut, prog[i]); end
    end
    bus.addressIn = 8'd40;
    tick();
    checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== Nop) begin fails++;
      $display("FAIL fetch_oor40: got v=%b d=%b expected v=1 d=%b",
               bus.dataValidOut, bus.dataOut, Nop); end
    idle();
    tick();
  endtask

  task automatic test_load_oor();
    bus.loadValidIn = 1'b1;
    bus.loadAddrIn  = 8'd50;
    bus.loadDataIn  = 4'b1010;
    tick();
    idle();
    checks++; if (bus.loadErrOut !== 1'b1) begin fails++;
      $display("FAIL load_err_pulse: got %b expected 1", bus.loadErrOut); end
    tick();
    checks++; if (bus.loadErrOut !== 1'b0) begin fails++;
      $display("FAIL load_err_clear: got %b expected 0", bus.loadErrOut); end
    bus.fetchEnIn = 1'b1;
    bus.addressIn = 8'd50;
    tick();
    checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== Nop) begin fails++;
      $display("FAIL fetch50: got v=%b d=%b expected v=1 d=%b",
               bus.dataValidOut, bus.dataOut, Nop); end
    // An in-range load must not raise the error flag.
    idle();
    bus.loadValidIn = 1'b1;
    bus.loadAddrIn  = 8'd31;
    bus.loadDataIn  = 4'b0111;
    tick();
    idle();
    checks++; if (bus.loadErrOut !== 1'b0) begin fails++;
      $display("FAIL load_err_inrange: got %b expected 0", bus.loadErrOut); end
  endtask

  task automatic test_read_before_write();
    bus.loadValidIn = 1'b1;
    bus.loadAddrIn  = 8'd3;
    bus.loadDataIn  = 4'b1001;
    bus.fetchEnIn   = 1'b1;
    bus.addressIn   = 8'd3;
    tick();
    bus.loadValidIn = 1'b0;
    checks++; if (bus.dataOut !== 4'b0010) begin fails++;
      $display("FAIL rbw_old: got %b expected 0010", bus.dataOut); end
    tick();
    checks++; if (bus.dataOut !== 4'b1001) begin fails++;
      $display("FAIL rbw_new: got %b expected 1001", bus.dataOut); end
    idle();
    tick();
  endtask

  task automatic test_clear();
    int n;
    bus.clearReqIn  = 1'b1;
    bus.loadValidIn = 1'b1;
    bus.loadAddrIn  = 8'd5;
    bus.loadDataIn  = 4'b1111;
    tick();
    idle();
    bus.fetchEnIn = 1'b1;
    n = 0;
    while (bus.loadReadyOut !== 1'b1 && n < 100) begin
      n++;
      tick();
      checks++; if (bus.dataValidOut !== 1'b0 || bus.dataOut !== 4'b1001) begin fails++;
        $display("FAIL clear_fetch_ignored: got v=%b d=%b expected v=0 d=1001",
                 bus.dataValidOut, bus.dataOut); end
    end
    checks++; if (n != 32) begin fails++;
      $display("FAIL clear_len: got %0d cycles expected 32", n); end
    for (int a = 0; a < 32; a++) begin
      bus.addressIn = 8'(a);
      tick();
      checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== Nop) begin fails++;
        $display("FAIL clear_fetch[%0d]: got v=%b d=%b expected v=1 d=%b",
                 a, bus.dataValidOut, bus.dataOut, Nop); end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int n;
    bus.loadValidIn = 1'b1;
    bus.loadAddrIn  = 8'd1;
    bus.loadDataIn  = 4'b0001;
    tick();
    idle();
    bus.fetchEnIn = 1'b1;
    bus.addressIn = 8'd1;
    tick();
    checks++; if (bus.dataOut !== 4'b0001) begin fails++;
      $display("FAIL pre_reset_fetch: got %b expected 0001", bus.dataOut); end
    idle();
    bus.clearReqIn = 1'b1;
    tick();
    bus.clearReqIn = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    bus.fetchEnIn = 1'b1;
    bus.addressIn = 8'd1;
    tick();
    checks++; if (bus.dataValidOut !== 1'b0 || bus.dataOut !== Nop) begin fails++;
      $display("FAIL midfill_reset_out: got v=%b d=%b expected v=0 d=%b",
               bus.dataValidOut, bus.dataOut, Nop); end
    checks++; if (bus.busyOut !== 1'b1 || bus.loadReadyOut !== 1'b0) begin fails++;
      $display("FAIL midfill_reset_busy: got busy=%b ready=%b expected busy=1 ready=0",
               bus.busyOut, bus.loadReadyOut); end
    rst_n = 1'b1;
    idle();
    n = 0;
    while (bus.busyOut === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n != 32) begin fails++;
      $display("FAIL midfill_fill_len: got %0d cycles expected 32", n); end
    bus.fetchEnIn = 1'b1;
    bus.addressIn = 8'd1;
    tick();
    checks++; if (bus.dataValidOut !== 1'b1 || bus.dataOut !== Nop) begin fails++;
      $display("FAIL program_lost: got v=%b d=%b expected v=1 d=%b",
               bus.dataValidOut, bus.dataOut, Nop); end
    idle();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_fill_contents();
    test_load();
    test_load_oor();
    test_read_before_write();
    test_clear();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
